// File: rtl/npu_pkg.sv
// Shared definitions for the NPU custom-instruction path: sequencer states,
// decode constants for the NPU instruction, and default timeout settings.
package npu_pkg;

    // Sequencer states for the execute-stage NPU command issuer
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_WB   = 2'd3
    } npu_state_e;

    // Decode signature of the custom NPU instruction
    localparam logic [6:0] OPC_NPU    = 7'b0000000;
    localparam logic [3:0] ALU_OP_NPU = 4'hF;
    localparam logic [1:0] WB_SEL_NPU = 2'b11;

    // Defaults for the optional response watchdog
    localparam int          TIMEOUT_CYCLES_DEF = 1024;
    localparam logic [31:0] ERR_DATA_DEF       = 32'hDEAD_BEEF;

    // The NPU sees the sub-op in the upper bits and the command in the lower bits
    function automatic logic [9:0] pack_op(input logic [6:0] funct7, input logic [2:0] funct3);
        return {funct7, funct3};
    endfunction

endpackage

// File: rtl/npu_cmd_issue_if.sv
// Request/response channel between the execute-stage issuer (master)
// and the NPU (slave).
interface npu_cmd_issue_if #(
    parameter int DATA_W = 32
);
    logic              npu_req_valid;
    logic              npu_req_ready;
    logic [9:0]        npu_req_op;
    logic [DATA_W-1:0] npu_req_a;
    logic [DATA_W-1:0] npu_req_b;
    logic              npu_rsp_valid;
    logic [DATA_W-1:0] npu_rsp_data;
    logic              npu_rsp_ready;

    modport master (
        output npu_req_valid, npu_req_op, npu_req_a, npu_req_b, npu_rsp_ready,
        input  npu_req_ready, npu_rsp_valid, npu_rsp_data
    );

    modport slave (
        input  npu_req_valid, npu_req_op, npu_req_a, npu_req_b, npu_rsp_ready,
        output npu_req_ready, npu_rsp_valid, npu_rsp_data
    );
endinterface

// File: rtl/npu_wdt.sv
// Response watchdog: counts cycles while enabled and flags expiry on the
// cycle the count reaches TIMEOUT_CYCLES-1, i.e. the TIMEOUT_CYCLES-th
// enabled cycle. Clear has priority over enable.
module npu_wdt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign expired = enable && !clear && (count_q == LAST);

    // Next count: restart on clear, hold at the limit once expired
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/npu_cmd_issue.sv
// Execute-stage sequencer for the custom NPU instruction. Accepts one decoded
// instruction, issues it to the NPU, stalls the pipeline until the result
// returns, then strobes it to writeback for one cycle.
// Optional feature macro: NPU_TIMEOUT_EN adds a response watchdog that
// completes the instruction with ERR_DATA and err=1 when the NPU goes silent.
module npu_cmd_issue
    import npu_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(ERR_DATA_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [2:0]          cmd_funct3,
    input  logic [6:0]          cmd_funct7,
    input  logic [DATA_W-1:0]   rs1_val,
    input  logic [DATA_W-1:0]   rs2_val,
    input  logic [4:0]          rd_addr,
    npu_cmd_issue_if.master     npu,
    output logic                stall,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [DATA_W-1:0]   wb_data,
    output logic                err
);
    npu_state_e        state_q, state_d;
    logic              req_valid_q, req_valid_d;
    logic [9:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [4:0]        rd_q, rd_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              err_q, err_d;
    logic              busy;
    logic              timeout;

    assign busy = (state_q == ST_REQ) || (state_q == ST_RSP);

`ifdef NPU_TIMEOUT_EN
    npu_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clear   (!busy),
        .enable  (busy),
        .expired (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Handshake-facing outputs decoded from registered state
    assign issue_ready       = (state_q == ST_IDLE);
    assign stall             = ((state_q == ST_IDLE) && issue_valid) || busy;
    assign npu.npu_req_valid = req_valid_q;
    assign npu.npu_req_op    = op_q;
    assign npu.npu_req_a     = a_q;
    assign npu.npu_req_b     = b_q;
    assign npu.npu_rsp_ready = (state_q == ST_IDLE) || (state_q == ST_RSP);
    assign wb_valid          = wb_valid_q;
    assign wb_rd             = rd_q;
    assign wb_data           = wb_data_q;
    assign err               = err_q;

    // Next-state and next-output logic; writes to rd 0 are suppressed on entry to WB
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rd_d        = rd_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        err_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (issue_valid) begin
                    state_d     = ST_REQ;
                    req_valid_d = 1'b1;
                    op_d        = pack_op(cmd_funct7, cmd_funct3);
                    a_d         = rs1_val;
                    b_d         = rs2_val;
                    rd_d        = rd_addr;
                end
            end
            ST_REQ: begin
                if (timeout) begin
                    state_d     = ST_WB;
                    req_valid_d = 1'b0;
                    wb_data_d   = ERR_DATA;
                    err_d       = 1'b1;
                    wb_valid_d  = (rd_q != 5'd0);
                end else if (npu.npu_req_ready) begin
                    state_d     = ST_RSP;
                    req_valid_d = 1'b0;
                end
            end
            ST_RSP: begin
                if (npu.npu_rsp_valid) begin
                    state_d    = ST_WB;
                    wb_data_d  = npu.npu_rsp_data;
                    wb_valid_d = (rd_q != 5'd0);
                end else if (timeout) begin
                    state_d    = ST_WB;
                    wb_data_d  = ERR_DATA;
                    err_d      = 1'b1;
                    wb_valid_d = (rd_q != 5'd0);
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer register: state plus every registered output and latched field
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_valid_q <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_npu_cmd_issue.sv
// Directed bench for npu_cmd_issue. The watchdog scenario is compiled in only
// when NPU_TIMEOUT_EN is defined, with the DUT watchdog shortened to 8 cycles.
module tb_npu_cmd_issue;
    logic        clk = 1'b0;
    logic        rst;
    logic        issueValid;
    logic        issueReady;
    logic [2:0]  cmdFunct3;
    logic [6:0]  cmdFunct7;
    logic [31:0] rs1Val;
    logic [31:0] rs2Val;
    logic [4:0]  rdAddr;
    logic        stall;
    logic        wbValid;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    logic        err;

    int checks = 0;
    int errors = 0;
    int reqHandshakes = 0;
    int hsBase;

    npu_cmd_issue_if #(.DATA_W(32)) npuBus ();

    npu_cmd_issue #(
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issueValid),
        .issue_ready (issueReady),
        .cmd_funct3  (cmdFunct3),
        .cmd_funct7  (cmdFunct7),
        .rs1_val     (rs1Val),
        .rs2_val     (rs2Val),
        .rd_addr     (rdAddr),
        .npu         (npuBus),
        .stall       (stall),
        .wb_valid    (wbValid),
        .wb_rd       (wbRd),
        .wb_data     (wbData),
        .err         (err)
    );

    // Free-running core clock
    always #5 clk = ~clk;

    // Count request handshakes as the NPU would see them
    always @(posedge clk) begin
        if (!rst && npuBus.npu_req_valid && npuBus.npu_req_ready) begin
            reqHandshakes++;
        end
    end

    // Advance to just after the next rising edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Present a decoded instruction (or clear issue_valid when valid=0)
    task automatic applyStimulus(input logic valid, input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        issueValid = valid;
        cmdFunct7  = f7;
        cmdFunct3  = f3;
        rs1Val     = a;
        rs2Val     = b;
        rdAddr     = rd;
        #1;
    endtask

    // Compare one observed value against the bench's expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Directed scenario sequence
    initial begin
        rst = 1'b1;
        npuBus.npu_req_ready = 1'b0;
        npuBus.npu_rsp_valid = 1'b0;
        npuBus.npu_rsp_data  = '0;
        applyStimulus(1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 5'd0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        #1;

        $display("[TB] reset values");
        checkOutput("rst_req_valid", {31'd0, npuBus.npu_req_valid}, 32'd0);
        checkOutput("rst_req_op", {22'd0, npuBus.npu_req_op}, 32'd0);
        checkOutput("rst_req_a", npuBus.npu_req_a, 32'd0);
        checkOutput("rst_req_b", npuBus.npu_req_b, 32'd0);
        checkOutput("rst_wb_valid", {31'd0, wbValid}, 32'd0);
        checkOutput("rst_wb_rd", {27'd0, wbRd}, 32'd0);
        checkOutput("rst_wb_data", wbData, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_issue_ready", {31'd0, issueReady}, 32'd1);
        checkOutput("rst_rsp_ready", {31'd0, npuBus.npu_rsp_ready}, 32'd1);
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);

        $display("[TB] basic issue, minimum latency");
        hsBase = reqHandshakes;
        npuBus.npu_req_ready = 1'b1;
        applyStimulus(1'b1, 7'h02, 3'b001, 32'h10, 32'h20, 5'd5);
        checkOutput("c0_stall", {31'd0, stall}, 32'd1);
        checkOutput("c0_issue_ready", {31'd0, issueReady}, 32'd1);
        nextCycle();
        applyStimulus(1'b0, 7'h7F, 3'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
        checkOutput("c1_req_valid", {31'd0, npuBus.npu_req_valid}, 32'd1);
        checkOutput("c1_req_op", {22'd0, npuBus.npu_req_op}, 32'h011);
        checkOutput("c1_req_a", npuBus.npu_req_a, 32'h10);
        checkOutput("c1_req_b", npuBus.npu_req_b, 32'h20);
        checkOutput("c1_issue_ready", {31'd0, issueReady}, 32'd0);
        checkOutput("c1_stall", {31'd0, stall}, 32'd1);
        nextCycle();
        checkOutput("c2_req_valid", {31'd0, npuBus.npu_req_valid}, 32'd0);
        checkOutput("c2_rsp_ready", {31'd0, npuBus.npu_rsp_ready}, 32'd1);
        checkOutput("c2_stall", {31'd0, stall}, 32'd1);
        checkOutput("c2_wb_valid", {31'd0, wbValid}, 32'd0);
        npuBus.npu_rsp_valid = 1'b1;
        npuBus.npu_rsp_data  = 32'hABCD;
        nextCycle();
        npuBus.npu_rsp_valid = 1'b0;
        npuBus.npu_rsp_data  = 32'h0;
        #1;
        checkOutput("c3_wb_valid", {31'd0, wbValid}, 32'd1);
        checkOutput("c3_wb_rd", {27'd0, wbRd}, 32'd5);
        checkOutput("c3_wb_data", wbData, 32'hABCD);
        checkOutput("c3_err", {31'd0, err}, 32'd0);
        checkOutput("c3_stall", {31'd0, stall}, 32'd0);
        checkOutput("c3_rsp_ready", {31'd0, npuBus.npu_rsp_ready}, 32'd0);
        nextCycle();
        checkOutput("c4_wb_valid", {31'd0, wbValid}, 32'd0);
        checkOutput("c4_issue_ready", {31'd0, issueReady}, 32'd1);
        checkOutput("basic_handshakes", reqHandshakes - hsBase, 32'd1);

        $display("[TB] request backpressure");
        hsBase = reqHandshakes;
        npuBus.npu_req_ready = 1'b0;
        applyStimulus(1'b1, 7'h40, 3'b101, 32'hAAAA_0001, 32'h5555_0002, 5'd7);
        nextCycle();
        applyStimulus(1'b0, 7'h00, 3'h0, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_req_valid", {31'd0, npuBus.npu_req_valid}, 32'd1);
            checkOutput("bp_req_op", {22'd0, npuBus.npu_req_op}, 32'h205);
            checkOutput("bp_req_a", npuBus.npu_req_a, 32'hAAAA_0001);
            checkOutput("bp_req_b", npuBus.npu_req_b, 32'h5555_0002);
            checkOutput("bp_stall", {31'd0, stall}, 32'd1);
            nextCycle();
        end
        npuBus.npu_req_ready = 1'b1;
        #1;
        checkOutput("bp_req_valid_at_hs", {31'd0, npuBus.npu_req_valid}, 32'd1);
        nextCycle();
        npuBus.npu_req_ready = 1'b0;
        #1;
        checkOutput("bp_req_valid_after", {31'd0, npuBus.npu_req_valid}, 32'd0);
        checkOutput("bp_stall_rsp", {31'd0, stall}, 32'd1);
        npuBus.npu_rsp_valid = 1'b1;
        npuBus.npu_rsp_data  = 32'h0000_0077;
        nextCycle();
        npuBus.npu_rsp_valid = 1'b0;
        #1;
        checkOutput("bp_wb_valid", {31'd0, wbValid}, 32'd1);
        checkOutput("bp_wb_rd", {27'd0, wbRd}, 32'd7);
        checkOutput("bp_wb_data", wbData, 32'h77);
        checkOutput("bp_handshakes", reqHandshakes - hsBase, 32'd1);
        nextCycle();

        $display("[TB] rd zero suppresses writeback");
        npuBus.npu_req_ready = 1'b1;
        applyStimulus(1'b1, 7'h01, 3'b000, 32'h1, 32'h2, 5'd0);
        nextCycle();
        applyStimulus(1'b0, 7'h00, 3'h0, 32'h0, 32'h0, 5'd0);
        nextCycle();
        npuBus.npu_rsp_valid = 1'b1;
        npuBus.npu_rsp_data  = 32'h1234;
        nextCycle();
        npuBus.npu_rsp_valid = 1'b0;
        #1;
        checkOutput("rd0_wb_valid", {31'd0, wbValid}, 32'd0);
        checkOutput("rd0_stall", {31'd0, stall}, 32'd0);
        checkOutput("rd0_in_wb", {31'd0, issueReady}, 32'd0);
        checkOutput("rd0_wb_data", wbData, 32'h1234);
        nextCycle();
        checkOutput("rd0_idle", {31'd0, issueReady}, 32'd1);
        checkOutput("rd0_wb_valid_after", {31'd0, wbValid}, 32'd0);

        $display("[TB] reset during RSP");
        applyStimulus(1'b1, 7'h05, 3'b011, 32'hCAFE, 32'hF00D, 5'd9);
        nextCycle();
        applyStimulus(1'b0, 7'h00, 3'h0, 32'h0, 32'h0, 5'd0);
        nextCycle();
        checkOutput("mr_in_rsp", {31'd0, npuBus.npu_rsp_ready}, 32'd1);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("mr_issue_ready", {31'd0, issueReady}, 32'd1);
        checkOutput("mr_req_valid", {31'd0, npuBus.npu_req_valid}, 32'd0);
        checkOutput("mr_wb_valid", {31'd0, wbValid}, 32'd0);
        checkOutput("mr_wb_rd", {27'd0, wbRd}, 32'd0);
        checkOutput("mr_req_op", {22'd0, npuBus.npu_req_op}, 32'd0);
        checkOutput("mr_req_a", npuBus.npu_req_a, 32'd0);
        npuBus.npu_rsp_valid = 1'b1;
        npuBus.npu_rsp_data  = 32'h999;
        nextCycle();
        npuBus.npu_rsp_valid = 1'b0;
        #1;
        checkOutput("mr_stray_wb_valid", {31'd0, wbValid}, 32'd0);
        checkOutput("mr_stray_wb_data", wbData, 32'd0);
        checkOutput("mr_stray_idle", {31'd0, issueReady}, 32'd1);
        checkOutput("mr_stray_stall", {31'd0, stall}, 32'd0);
        nextCycle();
        checkOutput("mr_stray_wb_valid2", {31'd0, wbValid}, 32'd0);

`ifdef NPU_TIMEOUT_EN
        $display("[TB] response timeout");
        applyStimulus(1'b1, 7'h03, 3'b010, 32'h5, 32'h6, 5'd6);
        nextCycle();
        applyStimulus(1'b0, 7'h00, 3'h0, 32'h0, 32'h0, 5'd0);
        for (int i = 1; i <= 8; i++) begin
            checkOutput("to_wait_wb_valid", {31'd0, wbValid}, 32'd0);
            checkOutput("to_wait_stall", {31'd0, stall}, 32'd1);
            nextCycle();
        end
        checkOutput("to_wb_valid", {31'd0, wbValid}, 32'd1);
        checkOutput("to_wb_data", wbData, 32'hDEAD_BEEF);
        checkOutput("to_err", {31'd0, err}, 32'd1);
        checkOutput("to_wb_rd", {27'd0, wbRd}, 32'd6);
        nextCycle();
        npuBus.npu_rsp_valid = 1'b1;
        npuBus.npu_rsp_data  = 32'h5555;
        nextCycle();
        npuBus.npu_rsp_valid = 1'b0;
        #1;
        checkOutput("to_late_wb_valid", {31'd0, wbValid}, 32'd0);
        checkOutput("to_late_err", {31'd0, err}, 32'd0);
        checkOutput("to_late_idle", {31'd0, issueReady}, 32'd1);
`endif

        $display("[TB] back-to-back instructions");
        hsBase = reqHandshakes;
        npuBus.npu_req_ready = 1'b1;
        applyStimulus(1'b1, 7'h01, 3'b010, 32'h1, 32'h2, 5'd3);
        nextCycle();
        applyStimulus(1'b0, 7'h00, 3'h0, 32'h0, 32'h0, 5'd0);
        checkOutput("b2b_a_op", {22'd0, npuBus.npu_req_op}, 32'h00A);
        checkOutput("b2b_a_a", npuBus.npu_req_a, 32'h1);
        nextCycle();
        npuBus.npu_rsp_valid = 1'b1;
        npuBus.npu_rsp_data  = 32'h1111;
        nextCycle();
        npuBus.npu_rsp_valid = 1'b0;
        applyStimulus(1'b1, 7'h03, 3'b011, 32'h3, 32'h4, 5'd4);
        checkOutput("b2b_a_wb_valid", {31'd0, wbValid}, 32'd1);
        checkOutput("b2b_a_wb_rd", {27'd0, wbRd}, 32'd3);
        checkOutput("b2b_a_wb_data", wbData, 32'h1111);
        checkOutput("b2b_wb_not_ready", {31'd0, issueReady}, 32'd0);
        checkOutput("b2b_wb_stall", {31'd0, stall}, 32'd0);
        nextCycle();
        checkOutput("b2b_b_accept", {31'd0, issueReady}, 32'd1);
        checkOutput("b2b_b_stall", {31'd0, stall}, 32'd1);
        nextCycle();
        applyStimulus(1'b0, 7'h00, 3'h0, 32'h0, 32'h0, 5'd0);
        checkOutput("b2b_b_req_valid", {31'd0, npuBus.npu_req_valid}, 32'd1);
        checkOutput("b2b_b_op", {22'd0, npuBus.npu_req_op}, 32'h01B);
        checkOutput("b2b_b_a", npuBus.npu_req_a, 32'h3);
        checkOutput("b2b_b_b", npuBus.npu_req_b, 32'h4);
        nextCycle();
        npuBus.npu_rsp_valid = 1'b1;
        npuBus.npu_rsp_data  = 32'h2222;
        nextCycle();
        npuBus.npu_rsp_valid = 1'b0;
        #1;
        checkOutput("b2b_b_wb_valid", {31'd0, wbValid}, 32'd1);
        checkOutput("b2b_b_wb_rd", {27'd0, wbRd}, 32'd4);
        checkOutput("b2b_b_wb_data", wbData, 32'h2222);
        checkOutput("b2b_handshakes", reqHandshakes - hsBase, 32'd2);
        nextCycle();
        checkOutput("b2b_end_wb_valid", {31'd0, wbValid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
